nr_frame_ctrl: RTL

//  Frame-level sequencer in front of the noise-reduction core on the AXI-Stream video path.

---
 rtl/nr_frame_ctrl_if.sv | 20 ++
 rtl/nr_frame_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/nr_frame_ctrl_if.sv
// nr_frame_ctrl_if
//  AXI-Stream style beat bus used on both sides of nr_frame_ctrl.
//  data  : pixel beat
//  valid : beat present
//  user  : start-of-frame marker
//  last  : end-of-line marker
//  ready : sink can take the beat
//  master drives data/valid/user/last; slave drives ready.
interface nr_frame_ctrl_if #(
  parameter int DW = 40
);
  logic [DW-1:0] data;
  logic          valid;
  logic          user;
  logic          last;
  logic          ready;

  modport master (output data, valid, user, last, input ready);
  modport slave  (input data, valid, user, last, output ready);
endinterface

// File: rtl/nr_frame_ctrl.sv
// nr_frame_ctrl
//  Frame sequencer in front of the noise-reduction core. Locks to SOF,
//  counts pixels/lines, regenerates user/last, latches bypass mode at frame
//  start only, flags malformed lines and resyncs on the next SOF.
//
// Ports
//  clk, rstn            clock, async active-low reset
//  cfg_enable           1 = run, 0 = stop at the next frame boundary
//  cfg_bypass           requested bypass, sampled on SOF beats only
//  s (slave)            upstream beat stream
//  m (master)           downstream beat stream, one register slice
//  nr_bypass            frame-stable bypass select
//  frame_done           pulse while the last beat of a clean frame is
//                       accepted downstream
//  err_early_eol        pulse: last before beat H_ACTIVE
//  err_late_eol         pulse: beat H_ACTIVE without last
//  err_sof              pulse: SOF marker mid-frame
//  frame_cnt            completed frame count
//
// Build option
//  NR_FRAME_CNT_EN      when defined, frame_cnt counts frame_done pulses
//                       (wrapping); otherwise it is tied to zero.
module nr_frame_ctrl #(
  parameter int DATA_WIDTH = 40,
  parameter int H_ACTIVE   = 1920,
  parameter int V_ACTIVE   = 1080
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   cfg_enable,
  input  logic                   cfg_bypass,
  nr_frame_ctrl_if.slave         s,
  nr_frame_ctrl_if.master        m,
  output logic                   nr_bypass,
  output logic                   frame_done,
  output logic                   err_early_eol,
  output logic                   err_late_eol,
  output logic                   err_sof,
  output logic [15:0]            frame_cnt
);

  localparam int PW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int LW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam logic [PW-1:0] PIX_LAST  = PW'(H_ACTIVE - 1);
  localparam logic [LW-1:0] LINE_LAST = LW'(V_ACTIVE - 1);

  typedef enum logic [1:0] {IDLE, WAIT_SOF, ACTIVE, RESYNC} state_t;

  state_t                state_q, state_d;
  logic [PW-1:0]         pix_q, pix_d, pix_cur;
  logic [LW-1:0]         line_q, line_d, line_cur;
  logic                  bypass_q, bypass_d;

  logic                  valid_q, user_q, last_q, eof_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  early_q, late_q, sof_err_q;

  logic                  out_free, s_ready_c;
  logic                  beat, sof, e_sof;
  logic                  ld_last, ld_eof, e_early, e_late;

  // Output slot can take a new beat this cycle.
  assign out_free = !valid_q || m.ready;

  always_comb begin
    state_d   = state_q;
    pix_d     = pix_q;
    line_d    = line_q;
    bypass_d  = bypass_q;
    s_ready_c = 1'b0;
    beat      = 1'b0;
    sof       = 1'b0;
    e_sof     = 1'b0;
    ld_last   = 1'b0;
    ld_eof    = 1'b0;
    e_early   = 1'b0;
    e_late    = 1'b0;

    case (state_q)
      IDLE: begin
        if (cfg_enable) state_d = WAIT_SOF;
      end
      WAIT_SOF, RESYNC: begin
        // Non-SOF beats are swallowed freely; an SOF beat is forwarded, so
        // it must wait for the output slot if the previous frame's final
        // beat is still stalled there.
        s_ready_c = !(s.valid && s.user) || out_free;
        if (s.valid && s.user && out_free) begin
          beat = 1'b1;
          sof  = 1'b1;
        end else if (!cfg_enable) begin
          state_d = IDLE;
        end
      end
      ACTIVE: begin
        s_ready_c = out_free;
        if (s.valid && out_free) begin
          beat = 1'b1;
          if (s.user) begin
            sof   = 1'b1;
            e_sof = (pix_q != '0) || (line_q != '0);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A SOF beat is pixel 0 of line 0 regardless of the running counters.
    pix_cur  = sof ? '0 : pix_q;
    line_cur = sof ? '0 : line_q;

    if (beat) begin
      state_d = ACTIVE;
      pix_d   = pix_cur + 1'b1;
      line_d  = line_cur;
      if (sof) bypass_d = cfg_bypass;
      // A mid-frame SOF restarts the frame; line-length checks are skipped
      // for that beat.
      if (!e_sof) begin
        if (pix_cur == PIX_LAST) begin
          ld_last = 1'b1;
          pix_d   = '0;
          if (!s.last) begin
            e_late  = 1'b1;
            line_d  = '0;
            state_d = RESYNC;
          end else if (line_cur == LINE_LAST) begin
            ld_eof  = 1'b1;
            line_d  = '0;
            state_d = cfg_enable ? WAIT_SOF : IDLE;
          end else begin
            line_d = line_cur + 1'b1;
          end
        end else if (s.last) begin
          ld_last = 1'b1;
          e_early = 1'b1;
          pix_d   = '0;
          line_d  = '0;
          state_d = RESYNC;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      pix_q     <= '0;
      line_q    <= '0;
      bypass_q  <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      user_q    <= 1'b0;
      last_q    <= 1'b0;
      eof_q     <= 1'b0;
      early_q   <= 1'b0;
      late_q    <= 1'b0;
      sof_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pix_q     <= pix_d;
      line_q    <= line_d;
      bypass_q  <= bypass_d;
      if (beat) begin
        valid_q <= 1'b1;
        data_q  <= s.data;
        user_q  <= sof;
        last_q  <= ld_last;
        eof_q   <= ld_eof;
      end else if (m.ready) begin
        valid_q <= 1'b0;
      end
      early_q   <= e_early;
      late_q    <= e_late;
      sof_err_q <= e_sof;
    end
  end

  assign s.ready       = s_ready_c;
  assign m.valid       = valid_q;
  assign m.data        = data_q;
  assign m.user        = user_q && valid_q;
  assign m.last        = last_q && valid_q;
  assign nr_bypass     = bypass_q;
  // eof_q is only set on the final beat of a frame with no line errors.
  assign frame_done    = valid_q && m.ready && eof_q;
  assign err_early_eol = early_q;
  assign err_late_eol  = late_q;
  assign err_sof       = sof_err_q;

`ifdef NR_FRAME_CNT_EN
  logic [15:0] fcnt_q;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)           fcnt_q <= '0;
    else if (frame_done) fcnt_q <= fcnt_q + 16'd1;
  end
  assign frame_cnt = fcnt_q;
`else
  assign frame_cnt = 16'h0000;
`endif

endmodule
